// File: rtl/multi_controller_poller.sv
// Serial gamepad poller: latches and clocks NUM_CONTROLLERS shift-register pads, shifts in
// active-low data and publishes held buttons plus sticky newly-pressed flags once per frame.
module multi_controller_poller #(
    parameter int NUM_CONTROLLERS  = 2,
    parameter int NUM_BUTTONS      = 8,
    parameter int CLK_DIV          = 1,
    parameter int AUTO_POLL_PERIOD = 0
) (
    input  logic                                   clk_1,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic                                   ack,
    input  logic [NUM_CONTROLLERS-1:0]             controller_data_B,
    output logic                                   controller_clk,
    output logic                                   controller_latch,
    output logic [NUM_CONTROLLERS*NUM_BUTTONS-1:0] buttons_out,
    output logic [NUM_CONTROLLERS*NUM_BUTTONS-1:0] pressed_out,
    output logic                                   busy,
    output logic                                   valid
);

    localparam int W  = NUM_CONTROLLERS * NUM_BUTTONS;
    localparam int DW = $clog2(2 * CLK_DIV + 1);
    localparam int BW = $clog2(NUM_BUTTONS);
    localparam int AW = (AUTO_POLL_PERIOD > 1) ? $clog2(AUTO_POLL_PERIOD) : 1;

    localparam logic [DW-1:0] LATCH_LAST = DW'(2 * CLK_DIV - 1);
    localparam logic [DW-1:0] HALF_LAST  = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(NUM_BUTTONS - 1);
    localparam logic [AW-1:0] AUTO_LAST  = (AUTO_POLL_PERIOD > 0) ? AW'(AUTO_POLL_PERIOD - 1) : '0;

    typedef enum logic [2:0] {S_IDLE, S_LATCH, S_LOW, S_HIGH, S_DONE} state_t;

    state_t                   r_state;
    state_t                   w_next;
    logic [DW-1:0]            r_div;
    logic [BW-1:0]            r_bit;
    logic [AW-1:0]            r_auto_cnt;
    logic [NUM_BUTTONS-1:0]   r_shift [NUM_CONTROLLERS];
    logic [W-1:0]             w_captured;
    logic [W-1:0]             r_buttons;
    logic [W-1:0]             r_pressed;
    logic                     r_valid;
    logic                     w_expire;
    logic                     w_go;
    logic                     w_phase_end;

    assign w_expire    = (AUTO_POLL_PERIOD > 0) && (r_auto_cnt == AUTO_LAST);
    assign w_go        = (r_state == S_IDLE) && (start || w_expire);
    assign w_phase_end = (r_state == S_LATCH) ? (r_div == LATCH_LAST) : (r_div == HALF_LAST);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_1 or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // NOTE: w_next gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_go)        w_next = S_LATCH;
            S_LATCH: if (w_phase_end) w_next = S_LOW;
            S_LOW:   if (w_phase_end) w_next = (r_bit == BIT_LAST) ? S_DONE : S_HIGH;
            S_HIGH:  if (w_phase_end) w_next = S_LOW;
            S_DONE:                   w_next = S_IDLE;
            default:                  w_next = S_IDLE;
        endcase
    end

    // NOTE: the capture array is cleared on reset so an aborted poll can never leak stale bits.
    always_ff @(posedge clk_1 or posedge rst) begin
        if (rst) begin
            r_div   <= '0;
            r_bit   <= '0;
            r_shift <= '{default: '0};
        end else begin
            if ((r_state == S_LATCH || r_state == S_LOW || r_state == S_HIGH) && !w_phase_end)
                r_div <= r_div + 1'b1;
            else
                r_div <= '0;

            if (r_state == S_LATCH)
                r_bit <= '0;
            else if (r_state == S_HIGH && w_phase_end)
                r_bit <= r_bit + 1'b1;

            // Sample at the end of the low half, just before the pad shifts on the rising clock.
            if (r_state == S_LOW && w_phase_end)
                for (int i = 0; i < NUM_CONTROLLERS; i++)
                    r_shift[i][r_bit] <= ~controller_data_B[i];
        end
    end

    always_comb begin
        w_captured = '0;
        for (int i = 0; i < NUM_CONTROLLERS; i++)
            w_captured[i*NUM_BUTTONS +: NUM_BUTTONS] = r_shift[i];
    end

    always_ff @(posedge clk_1 or posedge rst) begin
        if (rst) begin
            r_buttons <= '0;
            r_pressed <= '0;
            r_valid   <= 1'b0;
        end else begin
            r_valid <= (r_state == S_DONE);
            if (r_state == S_DONE) begin
                r_buttons <= w_captured;
                r_pressed <= (r_pressed & ~{W{ack}}) | (w_captured & ~r_buttons);
            end else if (ack) begin
                r_pressed <= '0;
            end
        end
    end

    // Free-running period counter, re-phased to every poll start; expiries while busy just wrap.
    always_ff @(posedge clk_1 or posedge rst) begin
        if (rst)                        r_auto_cnt <= '0;
        else if (AUTO_POLL_PERIOD == 0) r_auto_cnt <= '0;
        else if (w_go || w_expire)      r_auto_cnt <= '0;
        else                            r_auto_cnt <= r_auto_cnt + 1'b1;
    end

    assign controller_clk   = (r_state == S_HIGH);
    assign controller_latch = (r_state == S_LATCH);
    assign busy             = (r_state == S_LATCH) || (r_state == S_LOW) || (r_state == S_HIGH);
    assign buttons_out      = r_buttons;
    assign pressed_out      = r_pressed;
    assign valid            = r_valid;

endmodule

// File: tb/tb_multi_controller_poller.sv
// Directed bench for multi_controller_poller: three instances (NES D=1, SNES D=4, auto-poll)
// driven by behavioural shift-register pads.
module tb_multi_controller_poller;

    logic clk_1 = 1'b0;
    always #5 clk_1 = ~clk_1;

    logic rst;
    logic ack;
    logic a_start, b_start, c_start;

    logic [1:0]  a_data, b_data, c_data;
    logic        a_cclk, a_latch, a_busy, a_valid;
    logic        b_cclk, b_latch, b_busy, b_valid;
    logic        c_cclk, c_latch, c_busy, c_valid;
    logic [15:0] a_buttons, a_pressed, c_buttons, c_pressed;
    logic [31:0] b_buttons, b_pressed;

    multi_controller_poller #(.NUM_CONTROLLERS(2), .NUM_BUTTONS(8), .CLK_DIV(1), .AUTO_POLL_PERIOD(0)) dut_a (
        .clk_1(clk_1), .rst(rst), .start(a_start), .ack(ack), .controller_data_B(a_data),
        .controller_clk(a_cclk), .controller_latch(a_latch), .buttons_out(a_buttons),
        .pressed_out(a_pressed), .busy(a_busy), .valid(a_valid));

    multi_controller_poller #(.NUM_CONTROLLERS(2), .NUM_BUTTONS(16), .CLK_DIV(4), .AUTO_POLL_PERIOD(0)) dut_b (
        .clk_1(clk_1), .rst(rst), .start(b_start), .ack(ack), .controller_data_B(b_data),
        .controller_clk(b_cclk), .controller_latch(b_latch), .buttons_out(b_buttons),
        .pressed_out(b_pressed), .busy(b_busy), .valid(b_valid));

    multi_controller_poller #(.NUM_CONTROLLERS(2), .NUM_BUTTONS(8), .CLK_DIV(1), .AUTO_POLL_PERIOD(100)) dut_c (
        .clk_1(clk_1), .rst(rst), .start(c_start), .ack(ack), .controller_data_B(c_data),
        .controller_clk(c_cclk), .controller_latch(c_latch), .buttons_out(c_buttons),
        .pressed_out(c_pressed), .busy(c_busy), .valid(c_valid));

    // Pads: parallel load while latched, shift toward bit 0 on each rising pad clock.
    logic [7:0]  a_val0 = '0, a_val1 = '0, a_sr0 = '0, a_sr1 = '0;
    logic [15:0] b_val0 = '0, b_val1 = '0, b_sr0 = '0, b_sr1 = '0;

    always @(posedge a_cclk or posedge a_latch)
        if (a_latch) begin a_sr0 <= a_val0; a_sr1 <= a_val1; end
        else begin a_sr0 <= {1'b0, a_sr0[7:1]}; a_sr1 <= {1'b0, a_sr1[7:1]}; end

    always @(posedge b_cclk or posedge b_latch)
        if (b_latch) begin b_sr0 <= b_val0; b_sr1 <= b_val1; end
        else begin b_sr0 <= {1'b0, b_sr0[15:1]}; b_sr1 <= {1'b0, b_sr1[15:1]}; end

    assign a_data = {~a_sr1[0], ~a_sr0[0]};
    assign b_data = {~b_sr1[0], ~b_sr0[0]};
    assign c_data = 2'b11;

    int   sel = 0;
    logic m_latch, m_cclk, m_busy, m_valid;
    assign m_latch = (sel == 1) ? b_latch : a_latch;
    assign m_cclk  = (sel == 1) ? b_cclk  : a_cclk;
    assign m_busy  = (sel == 1) ? b_busy  : a_busy;
    assign m_valid = (sel == 1) ? b_valid : a_valid;

    int err_cnt = 0;
    int chk_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One poll on instance s; cycle index 0 is the cycle right after the start-sampling edge.
    task automatic run_poll(input int s, input int lat_exp, input int latch_exp, input int pulses_exp,
                            input int high_exp, input int ack_at, input string tag);
        int   n, vidx, latch_cyc, pulses, high_cyc, overlap, busy_end;
        logic prev_clk;
        sel = s;
        @(negedge clk_1);
        if (s == 1) b_start = 1'b1; else a_start = 1'b1;
        @(posedge clk_1);
        #1;
        a_start = 1'b0;
        b_start = 1'b0;
        n = 0; vidx = -1; latch_cyc = 0; pulses = 0; high_cyc = 0; overlap = 0; busy_end = 1;
        prev_clk = 1'b0;
        while (vidx < 0 && n < 400) begin
            @(negedge clk_1);
            if (n == 0) check({tag, "_busy_on"}, 32'(m_busy), 32'd1);
            if (m_latch) latch_cyc++;
            if (m_cclk) high_cyc++;
            if (m_cclk && !prev_clk) pulses++;
            if (m_cclk && m_latch) overlap++;
            prev_clk = m_cclk;
            if (ack_at > 0) ack = (n == ack_at - 1);
            if (m_valid) begin
                vidx = n;
                busy_end = int'(m_busy);
            end
            n++;
        end
        ack = 1'b0;
        check({tag, "_latency"}, vidx, lat_exp);
        check({tag, "_latch_cycles"}, latch_cyc, latch_exp);
        check({tag, "_clk_pulses"}, pulses, pulses_exp);
        check({tag, "_clk_high_cycles"}, high_cyc, high_exp);
        check({tag, "_latch_clk_overlap"}, overlap, 0);
        check({tag, "_busy_at_valid"}, busy_end, 0);
        @(negedge clk_1);
        check({tag, "_valid_one_cycle"}, 32'(m_valid), 32'd0);
    endtask

    initial begin
        int   nl, nv, firstv, lastv, nr, lastr, bad;
        logic prev_l;

        rst = 1'b1; ack = 1'b0;
        a_start = 1'b0; b_start = 1'b0; c_start = 1'b0;
        repeat (3) @(negedge clk_1);
        check("rst_clk",     32'(a_cclk),  32'd0);
        check("rst_latch",   32'(a_latch), 32'd0);
        check("rst_busy",    32'(a_busy),  32'd0);
        check("rst_valid",   32'(a_valid), 32'd0);
        check("rst_buttons", 32'(a_buttons), 32'd0);
        check("rst_pressed", 32'(a_pressed), 32'd0);
        rst = 1'b0;

        // Basic NES frame.
        a_val0 = 8'hFE; a_val1 = 8'h7F;
        run_poll(0, 18, 2, 7, 7, 0, "t1");
        check("t1_buttons", 32'(a_buttons), 32'h7FFE);
        check("t1_pressed", 32'(a_pressed), 32'h7FFE);

        // ack outside DONE, then sticky newly-pressed tracking.
        @(negedge clk_1); ack = 1'b1;
        @(negedge clk_1); ack = 1'b0;
        check("t3_ack_clear", 32'(a_pressed), 32'h0000);
        check("t3_ack_keeps_buttons", 32'(a_buttons), 32'h7FFE);
        a_val0 = 8'h00;
        run_poll(0, 18, 2, 7, 7, 0, "t3a");
        check("t3a_buttons", 32'(a_buttons), 32'h7F00);
        check("t3a_pressed", 32'(a_pressed), 32'h0000);
        a_val0 = 8'h05;
        run_poll(0, 18, 2, 7, 7, 0, "t3b");
        check("t3b_pressed", 32'(a_pressed), 32'h0005);
        run_poll(0, 18, 2, 7, 7, 0, "t3c");
        check("t3c_sticky", 32'(a_pressed), 32'h0005);
        a_val0 = 8'h0D;
        run_poll(0, 18, 2, 7, 7, 18, "t3d");
        check("t3d_ack_in_done", 32'(a_pressed), 32'h0008);
        check("t3d_buttons", 32'(a_buttons), 32'h7F0D);

        // SNES, divided clock.
        b_val0 = 16'hA5C3; b_val1 = 16'h1234;
        run_poll(1, 133, 8, 15, 60, 0, "t2");
        check("t2_buttons", b_buttons, 32'h1234A5C3);
        check("t2_pressed", b_pressed, 32'h1234A5C3);

        // start held high: polls every latency+1 cycles.
        sel = 0;
        @(negedge clk_1); a_start = 1'b1;
        nl = 0; nv = 0; firstv = -1; lastv = -1; prev_l = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_1);
            if (a_latch && !prev_l) nl++;
            prev_l = a_latch;
            if (a_valid) begin
                if (lastv >= 0) check("t4_valid_spacing", i - lastv, 19);
                else firstv = i;
                lastv = i;
                nv++;
            end
            if (i == 59) a_start = 1'b0;
        end
        check("t4_first_valid", firstv, 18);
        check("t4_latch_rises", nl, 4);
        check("t4_valid_count", nv, 4);

        // start pulses mid-poll and during DONE are ignored.
        @(negedge clk_1); a_start = 1'b1;
        nl = 0; nv = 0; prev_l = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_1);
            if (a_latch && !prev_l) nl++;
            prev_l = a_latch;
            if (a_valid) nv++;
            a_start = (i == 5) || (i == 10) || (i == 17);
        end
        a_start = 1'b0;
        check("t4_midpoll_latch_rises", nl, 1);
        check("t4_midpoll_valids", nv, 1);

        // Auto-poll instance has been free-running since reset release.
        nr = 0; lastr = -1; bad = 0; prev_l = c_latch;
        for (int i = 0; i < 320; i++) begin
            @(negedge clk_1);
            if (c_latch && !prev_l) begin
                if (lastr >= 0) check("t5_latch_period", i - lastr, 100);
                lastr = i;
                nr++;
            end
            prev_l = c_latch;
            if (c_valid && lastr >= 0 && (i - lastr) != 18) bad++;
        end
        check("t5_latch_count_ge3", 32'(nr >= 3), 32'd1);
        check("t5_valid_offset", bad, 0);

        // Reset during the 4th HIGH phase.
        @(negedge clk_1); a_start = 1'b1;
        @(posedge clk_1); #1 a_start = 1'b0;
        repeat (10) @(negedge clk_1);
        check("t6_in_high", 32'(a_cclk), 32'd1);
        check("t6_pre_pressed", 32'(a_pressed), 32'h0008);
        #1 rst = 1'b1;
        #1;
        check("t6_clk",     32'(a_cclk),  32'd0);
        check("t6_latch",   32'(a_latch), 32'd0);
        check("t6_busy",    32'(a_busy),  32'd0);
        check("t6_valid",   32'(a_valid), 32'd0);
        check("t6_buttons", 32'(a_buttons), 32'd0);
        check("t6_pressed", 32'(a_pressed), 32'd0);
        repeat (2) @(negedge clk_1);
        rst = 1'b0;
        nv = 0; nl = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_1);
            if (a_valid) nv++;
            if (a_cclk || a_latch) nl++;
        end
        check("t6_no_valid", nv, 0);
        check("t6_no_activity", nl, 0);
        run_poll(0, 18, 2, 7, 7, 0, "t6r");
        check("t6r_buttons", 32'(a_buttons), 32'h7F0D);
        check("t6r_pressed", 32'(a_pressed), 32'h7F0D);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
